// File: rtl/cic_interpolator.sv
// CIC interpolator: N low-rate combs, zero-stuffer by R, N high-rate
// integrators, with a valid/ready handshake on both sides.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   x, x_valid        low-rate input sample and its valid
//   x_ready           input accepted this cycle
//   y, y_valid        high-rate output sample and its valid
//   y_ready           downstream accepts y this cycle
module cic_interpolator #(
  parameter int N         = 3,
  parameter int R         = 4,
  parameter int M         = 1,
  parameter int PRECISION = 12,
  localparam int W        = PRECISION + N * $clog2(R * M)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic signed [PRECISION-1:0] x,
  input  logic                        x_valid,
  output logic                        x_ready,
  output logic signed [W-1:0]         y,
  output logic                        y_valid,
  input  logic                        y_ready
);

  if (N < 1 || N > 6) begin : g_bad_n
    $error("cic_interpolator: N must be 1..6");
  end
  if (R < 2 || R > 64) begin : g_bad_r
    $error("cic_interpolator: R must be 2..64");
  end
  if (M != 1 && M != 2) begin : g_bad_m
    $error("cic_interpolator: M must be 1 or 2");
  end

  localparam int PW = $clog2(R);
  localparam logic [PW-1:0] PLAST = PW'(R - 1);

  logic [PW-1:0]       phase_q, phase_d;
  logic signed [W-1:0] dly_q   [N][M];
  logic signed [W-1:0] integ_q [N];
  logic signed [W-1:0] integ_d [N];
  logic signed [W-1:0] comb_w  [N+1];
  logic signed [W-1:0] u_w;
  logic signed [W-1:0] y_q;
  logic                y_valid_q;
  logic                free_w;
  logic                step_w;
  logic                accept_w;

  assign free_w   = !y_valid_q || y_ready;
  assign step_w   = free_w && (phase_q != '0 || x_valid);
  assign accept_w = step_w && phase_q == '0;
  assign x_ready  = !rst && phase_q == '0 && free_w;
  assign y        = y_q;
  assign y_valid  = y_valid_q;

  always_comb begin
    comb_w[0] = {{(W - PRECISION){x[PRECISION-1]}}, x};
    for (int k = 0; k < N; k++) begin
      comb_w[k+1] = comb_w[k] - dly_q[k][M-1];
    end
    u_w = accept_w ? comb_w[N] : '0;
    // Later stages add the pre-step value of the stage before them.
    integ_d[0] = integ_q[0] + u_w;
    for (int k = 1; k < N; k++) begin
      integ_d[k] = integ_q[k] + integ_q[k-1];
    end
    phase_d = (phase_q == PLAST) ? '0 : phase_q + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q   <= '0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      for (int k = 0; k < N; k++) begin
        integ_q[k] <= '0;
        for (int j = 0; j < M; j++) begin
          dly_q[k][j] <= '0;
        end
      end
    end else if (step_w) begin
      phase_q   <= phase_d;
      y_q       <= integ_d[N-1];
      y_valid_q <= 1'b1;
      for (int k = 0; k < N; k++) begin
        integ_q[k] <= integ_d[k];
      end
      if (accept_w) begin
        for (int k = 0; k < N; k++) begin
          dly_q[k][0] <= comb_w[k];
          for (int j = 1; j < M; j++) begin
            dly_q[k][j] <= dly_q[k][j-1];
          end
        end
      end
    end else if (y_valid_q && y_ready) begin
      y_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cic_interpolator.sv
// Directed bench for cic_interpolator: three configurations share
// one stimulus stream; each step checks the instance it targets.
module tb_cic_interpolator;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [11:0] x;
  logic               x_valid;
  logic               y_ready;

  logic               xr3, yv3;
  logic signed [17:0] y3;
  logic               xr1, yv1;
  logic signed [13:0] y1;
  logic               xr2, yv2;
  logic signed [13:0] y2;

  int total = 0;
  int bad   = 0;
  int nbad  = 0;

  // N=3 R=4 step response, scaled for x=100
  int e3 [10] = '{0, 0, 100, 300, 600, 1000, 1300, 1500, 1600, 1600};
  // N=2 R=2 step response for x=1
  int e2 [6]  = '{0, 1, 2, 2, 2, 2};

  always #5 clk = ~clk;

  cic_interpolator #(.N(3), .R(4), .M(1), .PRECISION(12)) u_d3 (
    .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .x_ready(xr3),
    .y(y3), .y_valid(yv3), .y_ready(y_ready)
  );

  cic_interpolator #(.N(1), .R(4), .M(1), .PRECISION(12)) u_d1 (
    .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .x_ready(xr1),
    .y(y1), .y_valid(yv1), .y_ready(y_ready)
  );

  cic_interpolator #(.N(2), .R(2), .M(1), .PRECISION(12)) u_d2 (
    .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .x_ready(xr2),
    .y(y2), .y_valid(yv2), .y_ready(y_ready)
  );

  task automatic chk(input string tag,
                     input logic signed [31:0] obs,
                     input logic signed [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, want);
    end
  endtask

  initial begin
    rst     = 1'b1;
    x       = 12'sd100;
    x_valid = 1'b1;
    y_ready = 1'b1;

    // reset held two cycles with a valid sample waiting
    repeat (2) begin
      @(negedge clk);
      chk("rst_xready", xr3, 0);
      chk("rst_yvalid", yv3, 0);
      chk("rst_y", y3, 0);
    end
    rst = 1'b0;
    #1 chk("rel_xready", xr3, 1);

    // continuous step response, x_ready once every 4 cycles
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("step3_y", y3, e3[i]);
      chk("step3_v", yv3, 1);
      chk("step3_xr", xr3, 32'(i % 4 == 3));
    end

    // backpressure for 3 cycles at phase 0
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_pre_y", y3, e3[i]);
    end
    y_ready = 1'b0;
    #1 chk("bp_xr0", xr3, 0);
    repeat (3) begin
      @(negedge clk);
      chk("bp_hold_y", y3, e3[3]);
      chk("bp_hold_v", yv3, 1);
      chk("bp_hold_xr", xr3, 0);
    end
    y_ready = 1'b1;
    #1 chk("bp_xr1", xr3, 1);
    for (int i = 4; i < 10; i++) begin
      @(negedge clk);
      chk("bp_post_y", y3, e3[i]);
    end

    // one-cycle reset at phase 2 under traffic
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("mr_pre_y", y3, e3[i]);
    end
    rst = 1'b1;
    #1 chk("mr_xr", xr3, 0);
    @(negedge clk);
    chk("mr_v", yv3, 0);
    chk("mr_y", y3, 0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("mr_post_y", y3, e3[i]);
    end

    // full-scale negative DC for 1000 inputs
    rst = 1'b1;
    x   = -12'sd2048;
    @(negedge clk);
    rst  = 1'b0;
    nbad = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (i == 4) chk("neg_tr_y", y3, -12288);
      if (i >= 10 && y3 !== -18'sd32768) nbad++;
    end
    chk("neg_dc_errs", nbad, 0);
    chk("neg_dc_y", y3, -32768);

    // N=1: single impulse, then idle input, then zeros
    rst = 1'b1;
    x   = 12'sd5;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("n1_y0", y1, 5);
    chk("n1_v0", yv1, 1);
    chk("n1_xr0", xr1, 0);
    x_valid = 1'b0;
    x       = 12'sd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("n1_y", y1, 5);
      chk("n1_v", yv1, 1);
    end
    @(negedge clk);
    chk("n1_idle_v", yv1, 0);
    chk("n1_idle_y", y1, 5);
    chk("n1_idle_xr", xr1, 1);
    x_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("n1_zero_y", y1, 0);
      chk("n1_zero_v", yv1, 1);
      chk("n1_zero_xr", xr1, 32'(i % 4 == 3));
    end

    // N=2 R=2 unit step
    rst = 1'b1;
    x   = 12'sd1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("n2_y", y2, e2[i]);
      chk("n2_xr", xr2, 32'(i % 2 == 1));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
